// File: rtl/iter_alu_pkg.sv
// iter_alu_pkg: opcode, FSM-state and M-extension funct3 definitions for iter_alu.
package iter_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_PASSB = 4'b0011,
    ALU_OR    = 4'b0100,
    ALU_AND   = 4'b0101,
    ALU_XOR   = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SRL   = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_SLT   = 4'b1101,
    ALU_SLTU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/iter_alu_div.sv
// iter_alu_div: unsigned restoring divider, one quotient bit per cycle (built under ITER_ALU_DIV_EN).
// o_done/o_quo/o_rem reflect the final step combinationally so the caller captures on that edge.
`ifdef ITER_ALU_DIV_EN
module iter_alu_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quo, r_rem, r_dvs;
  logic [XLEN:0]   w_part, w_diff;
  logic            w_ge;

  // Partial remainder never exceeds 2*divisor-1, so the difference MSB is a clean borrow.
  assign w_part = {r_rem, r_quo[XLEN-1]};
  assign w_diff = w_part - {1'b0, r_dvs};
  assign w_ge   = ~w_diff[XLEN];
  assign o_rem  = w_ge ? w_diff[XLEN-1:0] : w_part[XLEN-1:0];
  assign o_quo  = {r_quo[XLEN-2:0], w_ge};
  assign o_done = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_start) begin
      r_cnt <= CW'(XLEN);
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      r_quo <= o_quo;
      r_rem <= o_rem;
    end
  end
endmodule
`endif

// File: rtl/iter_alu.sv
// iter_alu: single-issue ALU; base ops in one cycle, RV M-extension mul/div iterated one bit per cycle.
// Define ITER_ALU_DIV_EN to build the divider; otherwise div/rem return all-ones at latency 1.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            cf,
  output logic            zf,
  output logic            sf,
  output logic            vf,
  output logic            busy
);
  localparam int CW = $clog2(XLEN) + 1;

  state_e            r_state;
  logic [XLEN-1:0]   r_result, r_mcand;
  logic              r_cf, r_zf, r_sf, r_vf, r_out_valid, r_busy, r_neg;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [2:0]        r_f3;

  logic              w_accept, w_sub, w_cout, w_vf, w_a_sgn, w_b_sgn;
  logic [XLEN-1:0]   w_bx, w_sum, w_base_res, w_a_mag, w_b_mag, w_mul_res;
  logic [XLEN:0]     w_msum;
  logic [2*XLEN-1:0] w_acc_nxt, w_prod;

  assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;
  assign {cf, zf, sf, vf} = {r_cf, r_zf, r_sf, r_vf};

  // The adder subtracts whenever op[0] is set, so slt/sltu and undefined codes share its flags.
  assign w_sub = op[0];
  assign w_bx  = w_sub ? ~b : b;
  assign {w_cout, w_sum} = {1'b0, a} + {1'b0, w_bx} + {{XLEN{1'b0}}, w_sub};
  assign w_vf  = (a[XLEN-1] == w_bx[XLEN-1]) && (w_sum[XLEN-1] != a[XLEN-1]);

  always_comb begin
    w_base_res = '0;
    case (op[3:0])
      ALU_ADD, ALU_SUB: w_base_res = w_sum;
      ALU_PASSB:        w_base_res = b;
      ALU_OR:           w_base_res = a | b;
      ALU_AND:          w_base_res = a & b;
      ALU_XOR:          w_base_res = a ^ b;
      ALU_SLL:          w_base_res = a << b[SHW-1:0];
      ALU_SRL:          w_base_res = a >> b[SHW-1:0];
      ALU_SRA:          w_base_res = $signed(a) >>> b[SHW-1:0];
      ALU_SLT:          w_base_res = {{(XLEN-1){1'b0}}, w_sum[XLEN-1] ^ w_vf};
      ALU_SLTU:         w_base_res = {{(XLEN-1){1'b0}}, ~w_cout};
      default:          w_base_res = '0;
    endcase
  end

  // Mul and div both iterate on magnitudes; signedness of each operand depends on funct3.
  assign w_a_sgn = a[XLEN-1] && (op[2:0] == F3_MULH || op[2:0] == F3_MULHSU ||
                                 op[2:0] == F3_DIV  || op[2:0] == F3_REM);
  assign w_b_sgn = b[XLEN-1] && (op[2:0] == F3_MULH || op[2:0] == F3_DIV || op[2:0] == F3_REM);
  assign w_a_mag = w_a_sgn ? -a : a;
  assign w_b_mag = w_b_sgn ? -b : b;

  assign w_msum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_nxt = {w_msum, r_acc[XLEN-1:1]};
  assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_mul_res = (r_f3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef ITER_ALU_DIV_EN
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  logic            r_qneg, r_rneg;
  logic            w_div0, w_ovf, w_div_start, w_div_done;
  logic [XLEN-1:0] w_spec_res, w_quo, w_rem, w_div_res;

  assign w_div0      = (b == '0);
  assign w_ovf       = !op[0] && (a == MINV) && (&b);
  assign w_spec_res  = op[1] ? (w_div0 ? a : '0) : (w_div0 ? '1 : a);
  assign w_div_start = w_accept && op[4] && op[2] && !w_div0 && !w_ovf;
  assign w_div_res   = r_f3[1] ? (r_rneg ? -w_rem : w_rem) : (r_qneg ? -w_quo : w_quo);

  iter_alu_div #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_done     (w_div_done),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      {r_cf, r_zf, r_sf, r_vf} <= 4'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_neg       <= 1'b0;
      r_f3        <= '0;
`ifdef ITER_ALU_DIV_EN
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_MUL: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_res;
            {r_cf, r_zf, r_sf, r_vf} <= {1'b0, w_mul_res == '0, 2'b00};
          end
        end
`ifdef ITER_ALU_DIV_EN
        ST_DIV: if (w_div_done) begin
          r_state     <= ST_DONE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b1;
          r_result    <= w_div_res;
          {r_cf, r_zf, r_sf, r_vf} <= {1'b0, w_div_res == '0, 2'b00};
        end
`endif
        ST_DONE: if (out_ready) begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
        default: ;
      endcase

      // A new accept (IDLE, or DONE during handoff) overrides the retirement above.
      if (w_accept) begin
        r_f3 <= op[2:0];
        if (!op[4]) begin
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_base_res;
          {r_cf, r_zf, r_sf, r_vf} <= {w_cout, w_sum == '0, w_sum[XLEN-1], w_vf};
        end else if (!op[2]) begin
          r_state     <= ST_MUL;
          r_busy      <= 1'b1;
          r_out_valid <= 1'b0;
          r_cnt       <= CW'(XLEN);
          r_acc       <= {{XLEN{1'b0}}, w_b_mag};
          r_mcand     <= w_a_mag;
          r_neg       <= w_a_sgn ^ w_b_sgn;
        end
`ifdef ITER_ALU_DIV_EN
        else if (w_div0 || w_ovf) begin
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_spec_res;
          {r_cf, r_zf, r_sf, r_vf} <= {1'b0, w_spec_res == '0, 2'b00};
        end else begin
          r_state     <= ST_DIV;
          r_busy      <= 1'b1;
          r_out_valid <= 1'b0;
          r_qneg      <= w_a_sgn ^ w_b_sgn;
          r_rneg      <= w_a_sgn;
        end
`else
        else begin
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
          r_result    <= '1;
          {r_cf, r_zf, r_sf, r_vf} <= 4'b0;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed and random checks of iter_alu against an arithmetic reference model.
module tb_iter_alu;
  parameter int XLEN = 32;
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;

  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_SLT  = 5'b01101;
  localparam logic [4:0] OP_SLTU = 5'b01111, OP_MUL  = 5'b10000, OP_MULH = 5'b10001;
  localparam logic [4:0] OP_MULHU = 5'b10011, OP_DIV = 5'b10100, OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM  = 5'b10110, OP_REMU = 5'b10111;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, cf, zf, sf, vf, busy;
  logic [4:0] op;
  logic [XLEN-1:0] a, b, result;

  int checks = 0, errors = 0;
  logic [XLEN-1:0] exp_res;
  logic [3:0] exp_fl;

  iter_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cf(cf), .zf(zf), .sf(sf), .vf(vf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values; lat counts cycles from accept to out_valid.
  function automatic void model(input logic [4:0] o, input logic [XLEN-1:0] x, y,
                                output logic [XLEN-1:0] res, output logic [3:0] fl, output int lat);
    longint ua, ub, sa, sb, sr, smax, smin;
    logic c, v;
    logic [XLEN-1:0] sum;
    logic signed [2*XLEN:0] ea, eb, pr;
    ua = longint'(x); ub = longint'(y);
    sa = longint'($signed(x)); sb = longint'($signed(y));
    smax = (longint'(1) <<< (XLEN-1)) - 1; smin = -(longint'(1) <<< (XLEN-1));
    res = '0; fl = '0; lat = 1;
    if (!o[4]) begin
      sr  = o[0] ? sa - sb : sa + sb;
      v   = (sr > smax) || (sr < smin);
      c   = o[0] ? (ua >= ub) : (((ua + ub) >> XLEN) != 0);
      sum = XLEN'(o[0] ? ua - ub : ua + ub);
      case (o[3:0])
        4'b0000, 4'b0001: res = sum;
        4'b0011: res = y;
        4'b0100: res = x | y;
        4'b0101: res = x & y;
        4'b0111: res = x ^ y;
        4'b1000: res = x << y[SHW-1:0];
        4'b1001: res = x >> y[SHW-1:0];
        4'b1010: res = $signed(x) >>> y[SHW-1:0];
        4'b1101: res = XLEN'(sa < sb);
        4'b1111: res = XLEN'(ua < ub);
        default: res = '0;
      endcase
      fl = {c, sum == '0, sum[XLEN-1], v};
    end else begin
      if (!o[2]) begin
        if (o[2:0] == 3'b001 || o[2:0] == 3'b010) ea = $signed(x); else ea = {1'b0, x};
        if (o[2:0] == 3'b001) eb = $signed(y); else eb = {1'b0, y};
        pr  = ea * eb;
        res = (o[2:0] == 3'b000) ? pr[XLEN-1:0] : pr[2*XLEN-1:XLEN];
        lat = XLEN + 1;
      end else begin
`ifdef ITER_ALU_DIV_EN
        if (ub == 0) res = o[1] ? x : ONES;
        else if (o[0]) res = XLEN'(o[1] ? ua % ub : ua / ub);
        else res = XLEN'(o[1] ? sa % sb : sa / sb);
        lat = (ub == 0 || (!o[0] && sa == smin && sb == -1)) ? 1 : XLEN + 1;
`else
        res = ONES;
`endif
      end
      fl = {1'b0, res == '0, 2'b00};
    end
  endfunction

  task automatic run_op(input logic [4:0] o, input logic [XLEN-1:0] x, y, input string tag,
                        input bit hold);
    int el, lat, bcnt;
    model(o, x, y, exp_res, exp_fl, el);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); a = XLEN'($urandom); b = XLEN'($urandom);
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk); lat++; bcnt += int'(busy);
    end while (!out_valid && lat < 4 * XLEN);
    chk({tag, ".latency"}, 64'(lat), 64'(el));
    chk({tag, ".busy_cycles"}, 64'(bcnt), 64'(el > 1 ? XLEN : 0));
    chk({tag, ".result"}, 64'(result), 64'(exp_res));
    chk({tag, ".flags"}, 64'({cf, zf, sf, vf}), 64'(exp_fl));
    if (!hold) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".drained"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    logic [XLEN-1:0] x, y;
    logic [4:0] o;
    int el;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #12;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.result", 64'(result), 64'd0);
    chk("reset.flags", 64'({cf, zf, sf, vf}), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("reset.in_ready", 64'(in_ready), 64'd1);

    run_op(OP_SUB,  XLEN'(5), XLEN'(7), "sub", 0);
    run_op(OP_SLT,  XLEN'(5), XLEN'(7), "slt", 0);
    run_op(OP_SLTU, XLEN'(5), XLEN'(7), "sltu", 0);
    run_op(OP_ADD,  ~MINV, XLEN'(1), "add_ovf", 0);
    run_op(OP_ADD,  ONES, XLEN'(1), "add_carry", 0);
    run_op(OP_MULH, MINV, MINV, "mulh_min", 0);
    run_op(OP_MUL,  XLEN'(-3), XLEN'(5), "mul_neg", 0);
    run_op(OP_DIV,  XLEN'(-7), XLEN'(2), "div_neg", 0);
    run_op(OP_REM,  XLEN'(-7), XLEN'(2), "rem_neg", 0);
    run_op(OP_DIVU, XLEN'(7), '0, "divu_zero", 0);
    run_op(OP_REMU, XLEN'(9), '0, "remu_zero", 0);
    run_op(OP_REM,  MINV, ONES, "rem_ovf", 0);
    run_op(OP_DIV,  MINV, ONES, "div_ovf", 0);

    // Hold the result under back-pressure, then hand it off while accepting the next op.
    run_op(OP_MULHU, XLEN'(12345), ONES, "hold", 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold.result", 64'(result), 64'(exp_res));
      chk("hold.flags", 64'({cf, zf, sf, vf}), 64'(exp_fl));
      chk("hold.in_ready", 64'(in_ready), 64'd0);
      chk("hold.out_valid", 64'(out_valid), 64'd1);
    end
    model(OP_SUB, XLEN'(3), XLEN'(3), exp_res, exp_fl, el);
    out_ready = 1'b1; op = OP_SUB; a = XLEN'(3); b = XLEN'(3); in_valid = 1'b1; #1;
    chk("handoff.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("handoff.out_valid", 64'(out_valid), 64'd1);
    chk("handoff.result", 64'(result), 64'(exp_res));
    chk("handoff.flags", 64'({cf, zf, sf, vf}), 64'(exp_fl));
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

    // Reset in the middle of an iterative op: nothing may come out afterwards.
    @(negedge clk);
`ifdef ITER_ALU_DIV_EN
    op = OP_DIV;
`else
    op = OP_MULHU;
`endif
    a = XLEN'(1000); b = XLEN'(3); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midreset.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0; #1;
    chk("midreset.out_valid", 64'(out_valid), 64'd0);
    chk("midreset.busy", 64'(busy), 64'd0);
    chk("midreset.result", 64'(result), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (XLEN + 4) begin @(negedge clk); seen |= out_valid; end
    chk("midreset.no_result", 64'(seen), 64'd0);
    run_op(OP_DIV, XLEN'(-7), XLEN'(2), "after_reset", 0);

    for (int n = 0; n < 80; n++) begin
      o = 5'($urandom);
      x = ($urandom_range(0, 7) == 0) ? MINV : XLEN'($urandom);
      case ($urandom_range(0, 4))
        0: y = '0;
        1: y = ONES;
        2: y = XLEN'($urandom_range(1, 40));
        default: y = XLEN'($urandom);
      endcase
      run_op(o, x, y, $sformatf("rand%0d_op%0h", n, o), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, operand/result width; legal values even and >= 8.
REQ-002 The module SHALL have parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 The module SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The module SHALL have port in_valid  input  1  operation request.
REQ-006 The module SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 The module SHALL have port op  input  5  opcode; op[4]=0 base ALU op (alufn encoding), op[4]=1 M-extension op with op[2:0]=RV funct3.
REQ-008 The module SHALL have port a  input  XLEN  operand rs1.
REQ-009 The module SHALL have port b  input  XLEN  operand rs2/immediate; shift amount is b[SHW-1:0].
REQ-010 The module SHALL have port out_valid  output  1  result held valid.
REQ-011 The module SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The module SHALL have ports result  output  XLEN, and cf, zf, sf, vf  output  1 each, registered result and flags.
REQ-013 The module SHALL have port busy  output  1  high while an iterative op is in progress.

Function
REQ-014 Base ops SHALL be: 0000 add, 0001 sub, 0011 pass b, 0100 or, 0101 and, 0111 xor, 1000 sll, 1001 srl, 1010 sra, 1101 slt, 1111 sltu; undefined base codes SHALL yield result 0, flags from the adder.
REQ-015 Add/sub flags SHALL be: cf = carry-out of a+b or a+~b+1, zf = (sum==0), sf = sum[XLEN-1], vf = signed overflow; slt = sf^vf, sltu = ~cf.
REQ-016 M ops SHALL be funct3 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu; for M ops zf = (result==0), cf=sf=vf=0.
REQ-017 FSM SHALL have states IDLE, MUL, DIV, DONE; IDLE->DONE on base op accept, IDLE->MUL/DIV on M op accept, MUL/DIV->DONE after counter expiry, DONE->IDLE when out_ready.
REQ-018 Base ops SHALL have latency 1: out_valid high the cycle after accept.
REQ-019 Multiply SHALL be radix-2 shift-add over 2*XLEN-bit product with sign correction, exactly XLEN iteration cycles; out_valid at accept+XLEN+1.
REQ-020 Divide SHALL be restoring, on magnitudes with final sign fix, exactly XLEN iteration cycles; out_valid at accept+XLEN+1.
REQ-021 Divide by zero SHALL give quotient all-ones and remainder = a, latency 1 (no iteration).
REQ-022 Signed overflow (a = most negative, b = -1) SHALL give div = a, rem = 0, latency 1.
REQ-023 in_ready SHALL be high only in IDLE, or in DONE when out_ready is high (back-to-back accept same cycle as result handoff).
REQ-024 result and flags SHALL stay stable while out_valid high and out_ready low.
REQ-025 busy SHALL be high exactly in MUL and DIV states.
REQ-026 Operands SHALL be captured at accept; input changes afterward SHALL not affect the in-flight result.

Reset
REQ-027 On rst_n low, asynchronously: state IDLE, out_valid 0, busy 0, result 0, all flags 0, iteration counter 0; in_ready 1 after reset release.
REQ-028 Reset mid-iteration SHALL abandon the operation with no result emitted.

Configuration
REQ-029 Macro ITER_ALU_DIV_EN SHALL compile in the divider (funct3 100-111) per REQ-020..022.
REQ-030 Without ITER_ALU_DIV_EN, funct3 100-111 SHALL complete at latency 1 with result all-ones and no divider logic instantiated; multiply unaffected.

Structure
REQ-031 Package iter_alu_pkg SHALL hold the opcode enum, the FSM state typedef and the M-op funct3 constants.
REQ-032 The divider SHALL be sub-module iter_alu_div (start/done handshake, quotient and remainder outputs), instantiated only under ITER_ALU_DIV_EN.

Verification
REQ-033 XLEN=32: sub a=5, b=7 -> result 0xFFFFFFFE, cf=0, sf=1, vf=0; slt -> 1; sltu -> 1; each out_valid one cycle after accept.
REQ-034 mulh a=0x80000000, b=0x80000000 -> result 0x40000000, out_valid exactly 33 cycles after accept, busy high 32 cycles.
REQ-035 div a=-7, b=2 -> -3; rem -> -1; divu a=7, b=0 -> 0xFFFFFFFF; rem a=0x80000000, b=-1 -> 0, latency 1.
REQ-036 out_ready held low 10 cycles after result -> result/flags stable, in_ready 0; then out_ready with new in_valid -> handoff and accept same cycle.
REQ-037 rst_n pulsed low mid-divide -> out_valid 0 immediately, busy 0, next op completes correctly.
REQ-038 Repeat REQ-033 and REQ-035 with XLEN=16 and with ITER_ALU_DIV_EN undefined (div -> all-ones, latency 1).
